nearest_select: RTL and testbench

NEAREST_SELECT -- requirements
Module: nearest_select

---
 rtl/tsp_pkg.sv | 14 +
 rtl/nearest_select.sv | 105 ++++++++++
 tb/tb_nearest_select.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tsp_pkg.sv
// Shared TSP constants and the nearest-select state encoding.
package tsp_pkg;

  localparam int CITY_W = 6;
  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_COLLECT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/nearest_select.sv
// Scans decoder candidates, looks up each distance from cur_city and keeps the nearest one.
module nearest_select
  import tsp_pkg::*;
#(
  parameter int DIST_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CITY_W-1:0] cur_city,
  output logic              dec_start,
  input  logic              dec_idle,
  input  logic              dec_valid,
  input  logic [CITY_W-1:0] dec_position,
  output logic [ADDR_W-1:0] dist_addr,
  input  logic [DIST_W-1:0] dist_data,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [CITY_W-1:0] best_city,
  output logic [DIST_W-1:0] best_dist
);

  state_t              r_state;
  state_t              w_state_next;
  logic [CITY_W-1:0]   r_cur_city;
  logic                r_seen_busy;
  logic                r_valid_d;
  logic [CITY_W-1:0]   r_pos_d;
  logic                r_found;
  logic [CITY_W-1:0]   r_best_city;
  logic [DIST_W-1:0]   r_best_dist;
  logic                w_win;

  always_comb begin
    w_state_next = r_state;
    dec_start    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (dec_idle) begin
          dec_start    = 1'b1;
          w_state_next = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // Idle seen right after launch is stale; wait for the decoder to go busy first.
        if (dec_idle && r_seen_busy) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // First eligible candidate always wins, so an all-ones distance can still be recorded.
  assign w_win = (r_state == S_COLLECT) && r_valid_d && (r_pos_d != r_cur_city) &&
                 (!r_found || (dist_data < r_best_dist));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cur_city  <= '0;
      r_seen_busy <= 1'b0;
      r_valid_d   <= 1'b0;
      r_pos_d     <= '0;
      r_found     <= 1'b0;
      r_best_city <= '0;
      r_best_dist <= '1;
    end else begin
      r_state   <= w_state_next;
      r_valid_d <= (r_state == S_COLLECT) && dec_valid;
      r_pos_d   <= dec_position;

      if (r_state == S_LAUNCH) begin
        r_seen_busy <= 1'b0;
      end else if ((r_state == S_COLLECT) && !dec_idle) begin
        r_seen_busy <= 1'b1;
      end

      if ((r_state == S_IDLE) && start) begin
        r_cur_city  <= cur_city;
        r_found     <= 1'b0;
        r_best_dist <= '1;
      end else if (w_win) begin
        r_found     <= 1'b1;
        r_best_city <= r_pos_d;
        r_best_dist <= dist_data;
      end
    end
  end

  assign dist_addr = {r_cur_city, dec_position};
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign found     = r_found;
  assign best_city = r_best_city;
  assign best_dist = r_best_dist;

endmodule

// File: tb/tb_nearest_select.sv
// Directed bench for nearest_select: acts as decoder and distance RAM, checks against a min-search model.
module tb_nearest_select;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [5:0]    cur_city;
  logic          dec_start;
  logic          dec_idle;
  logic          dec_valid;
  logic [5:0]    dec_position;
  logic [11:0]   dist_addr;
  logic [DW-1:0] dist_data;
  logic          busy;
  logic          done;
  logic          found;
  logic [5:0]    best_city;
  logic [DW-1:0] best_dist;

  nearest_select #(.DIST_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cur_city     (cur_city),
    .dec_start    (dec_start),
    .dec_idle     (dec_idle),
    .dec_valid    (dec_valid),
    .dec_position (dec_position),
    .dist_addr    (dist_addr),
    .dist_data    (dist_data),
    .busy         (busy),
    .done         (done),
    .found        (found),
    .best_city    (best_city),
    .best_dist    (best_dist)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] tbl [64];

  // Synchronous-read distance RAM: data valid one cycle after the address.
  always @(posedge clk) dist_data <= tbl[dist_addr[5:0]];

  int            n_vec = 0;
  int            n_err = 0;
  int            done_seen = 0;
  logic          exp_found;
  logic [5:0]    exp_city;
  logic [DW-1:0] exp_dist;
  logic [5:0]    exp_cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Nearest = minimum distance over eligible candidates, lowest index among equals.
  function automatic void model(input int cur, input logic [63:0] mask);
    logic [DW-1:0] m;
    logic          any;
    m   = '1;
    any = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (mask[i] && i != cur) begin
        any = 1'b1;
        if (tbl[i] < m) m = tbl[i];
      end
    end
    exp_found = any;
    exp_dist  = m;
    exp_city  = '0;
    for (int i = 63; i >= 0; i--) begin
      if (mask[i] && i != cur && tbl[i] == m) exp_city = 6'(i);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        done_seen++;
        chk("done_found", 32'(found), 32'(exp_found));
        chk("done_dist", 32'(best_dist), 32'(exp_dist));
        if (exp_found) chk("done_city", 32'(best_city), 32'(exp_city));
      end
      if (busy && dec_valid) chk("addr_cur", 32'(dist_addr[11:6]), 32'(exp_cur));
    end
  end

  task automatic run(input int cur, input logic [63:0] mask, input bit hold);
    int k;
    model(cur, mask);
    if (hold) dec_idle = 1'b0;
    start    = 1'b1;
    cur_city = 6'(cur);
    exp_cur  = 6'(cur);
    tick();
    start = 1'b0;
    chk("busy_launch", 32'(busy), 32'd1);
    if (hold) begin
      chk("launch_hold_ds", 32'(dec_start), 32'd0);
      tick();
      chk("launch_hold_busy", 32'(busy), 32'd1);
      chk("launch_hold_ds2", 32'(dec_start), 32'd0);
      dec_idle = 1'b1;
      #1;
    end
    k = 0;
    while (!dec_start && k < 8) begin
      tick();
      k++;
    end
    chk("dec_start", 32'(dec_start), 32'd1);
    tick();
    dec_idle  = 1'b0;
    dec_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (mask[i]) begin
        dec_valid    = 1'b1;
        dec_position = 6'(i);
        tick();
      end
    end
    if (mask == 64'd0) tick();
    dec_valid = 1'b0;
    dec_idle  = 1'b1;
    tick();
    chk("done_timing", 32'(done), 32'd1);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
    chk("hold_found", 32'(found), 32'(exp_found));
    chk("hold_dist", 32'(best_dist), 32'(exp_dist));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] mask;
    for (int i = 0; i < 64; i++) tbl[i] = 16'(100 + i);
    reset        = 1'b1;
    start        = 1'b0;
    cur_city     = '0;
    dec_idle     = 1'b1;
    dec_valid    = 1'b0;
    dec_position = '0;
    exp_cur      = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_city", 32'(best_city), 32'd0);
    chk("rst_dist", 32'(best_dist), 32'hffff);
    chk("rst_dec_start", 32'(dec_start), 32'd0);
    reset = 1'b0;
    tick();

    tbl[5] = 16'd70; tbl[9] = 16'd20; tbl[40] = 16'd50;
    mask = '0; mask[5] = 1'b1; mask[9] = 1'b1; mask[40] = 1'b1;
    run(3, mask, 1'b0);
    chk("pin_basic_found", 32'(found), 32'd1);
    chk("pin_basic_city", 32'(best_city), 32'd9);
    chk("pin_basic_dist", 32'(best_dist), 32'd20);

    tbl[12] = 16'd33; tbl[13] = 16'd33;
    mask = '0; mask[12] = 1'b1; mask[13] = 1'b1;
    run(3, mask, 1'b0);
    chk("pin_tie_city", 32'(best_city), 32'd12);
    chk("pin_tie_dist", 32'(best_dist), 32'd33);

    run(3, 64'd0, 1'b0);
    chk("pin_empty_found", 32'(found), 32'd0);
    chk("pin_empty_dist", 32'(best_dist), 32'hffff);

    tbl[20] = 16'd1;
    mask = '0; mask[20] = 1'b1;
    run(20, mask, 1'b0);
    chk("pin_self_found", 32'(found), 32'd0);

    tbl[7] = 16'hffff; tbl[8] = 16'hffff;
    mask = '0; mask[7] = 1'b1; mask[8] = 1'b1;
    run(0, mask, 1'b0);
    chk("pin_ones_found", 32'(found), 32'd1);
    chk("pin_ones_city", 32'(best_city), 32'd7);

    tbl[1] = 16'd9; tbl[2] = 16'd4; tbl[3] = 16'd4;
    mask = '0; mask[1] = 1'b1; mask[2] = 1'b1; mask[3] = 1'b1;
    run(30, mask, 1'b1);

    for (int i = 0; i < 64; i++) tbl[i] = 16'(63 - i);
    run(10, '1, 1'b0);
    chk("pin_all_city", 32'(best_city), 32'd63);
    chk("pin_all_dist", 32'(best_dist), 32'd0);
    run(63, '1, 1'b0);
    chk("pin_all63_city", 32'(best_city), 32'd62);
    chk("pin_all63_dist", 32'(best_dist), 32'd1);

    chk("done_count", 32'(done_seen), 32'd8);

    // Second start while busy, then reset in the middle of collection.
    tbl[4] = 16'd5; tbl[6] = 16'd50;
    start    = 1'b1;
    cur_city = 6'd2;
    exp_cur  = 6'd2;
    tick();
    start = 1'b0;
    tick();
    dec_idle     = 1'b0;
    dec_valid    = 1'b1;
    dec_position = 6'd4;
    tick();
    dec_position = 6'd6;
    start        = 1'b1;
    cur_city     = 6'd50;
    tick();
    start     = 1'b0;
    dec_valid = 1'b0;
    chk("ignore_start_cur", 32'(dist_addr[11:6]), 32'd2);
    chk("mid_found", 32'(found), 32'd1);
    chk("mid_city", 32'(best_city), 32'd4);
    chk("mid_dist", 32'(best_dist), 32'd5);
    reset = 1'b1;
    tick();
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_found", 32'(found), 32'd0);
    chk("mrst_city", 32'(best_city), 32'd0);
    chk("mrst_dist", 32'(best_dist), 32'hffff);
    chk("mrst_dec_start", 32'(dec_start), 32'd0);
    reset    = 1'b0;
    dec_idle = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("mrst_no_done", 32'(done_seen), 32'd8);
    chk("mrst_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
